// File: rtl/demorgan_sweep_checker_pkg.sv
// Shared types and the De Morgan reference for the sweep checker.
// Vector encoding is {A,B}; responses are packed {nA,nB,nAornB}.
package demorgan_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int         NUM_VECTORS = 4;
    localparam logic [1:0] LAST_VEC    = 2'b11;

    function automatic logic [2:0] expected_resp(input logic [1:0] vec);
        return {~vec[1], ~vec[0], ~vec[1] | ~vec[0]};
    endfunction

endpackage

// File: rtl/demorgan_sweep_checker_if.sv
// Stimulus/response bundle between the checker (master) and the gate block (slave).
interface demorgan_sweep_checker_if;
    logic a_out;
    logic b_out;
    logic na_in;
    logic nb_in;
    logic naornb_in;

    modport master (output a_out, output b_out,
                    input  na_in, input  nb_in, input naornb_in);
    modport slave  (input  a_out, input  b_out,
                    output na_in, output nb_in, output naornb_in);
endinterface

// File: rtl/demorgan_sweep_checker_expect.sv
// Combinational expected-response model and 3-bit compare.
// Case inequality so X/Z on any response bit is flagged as a mismatch.
module demorgan_expect
    import demorgan_chk_pkg::*;
(
    input  logic [1:0] vec,
    input  logic [2:0] resp,
    output logic       mismatch
);
    always_comb begin
        mismatch = (resp !== expected_resp(vec));
    end
endmodule

// File: rtl/demorgan_sweep_checker.sv
// Sweeps {A,B} through 00..11 for NUM_PASSES passes, checks each vector after settling.
// Latency 1+4*NUM_PASSES*(SETTLE_CYCLES+1) cycles to done; start ignored unless idle.
module demorgan_sweep_checker
    import demorgan_chk_pkg::*;
#(
    parameter int NUM_PASSES    = 1,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    demorgan_sweep_checker_if.master           gate,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [CNT_W-1:0]                   err_count,
    output logic [1:0]                         first_fail_vec,
    output logic                               first_fail_valid
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [1:0]       ffvec_q, ffvec_d;
    logic             ffv_q, ffv_d;
    logic             pass_q, pass_d;
    logic             mismatch;

    demorgan_expect u_expect (
        .vec      (vec_q),
        .resp     ({gate.na_in, gate.nb_in, gate.naornb_in}),
        .mismatch (mismatch)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        scnt_d  = scnt_q;
        pcnt_d  = pcnt_q;
        err_d   = err_q;
        ffvec_d = ffvec_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d   = 2'b00;
                    err_d   = '0;
                    ffvec_d = 2'b00;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                    pcnt_d  = '0;
                    scnt_d  = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                scnt_d = scnt_q + SW'(1);
                if (scnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != {CNT_W{1'b1}}) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (!ffv_q) begin
                        ffvec_d = vec_q;
                        ffv_d   = 1'b1;
                    end
                end
                if (vec_q == LAST_VEC && pcnt_q == PW'(NUM_PASSES - 1)) begin
                    // Resolve pass here so it is already valid while done pulses.
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    if (vec_q == LAST_VEC) begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                    scnt_d  = '0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                vec_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 2'b00;
            scnt_q  <= '0;
            pcnt_q  <= '0;
            err_q   <= '0;
            ffvec_q <= 2'b00;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            scnt_q  <= scnt_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            ffvec_q <= ffvec_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    assign gate.a_out       = vec_q[1];
    assign gate.b_out       = vec_q[0];
    assign busy             = (state_q == SETTLE) || (state_q == CHECK);
    assign done             = (state_q == DONE);
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Bench: three checker instances around a configurable faulty gate model,
// table-driven directed runs, randomized fault masks and a mid-run reset.
module tb_demorgan_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start_v;
    int         mode;
    logic [2:0] mask [4];

    demorgan_sweep_checker_if g0 ();
    demorgan_sweep_checker_if g1 ();
    demorgan_sweep_checker_if g2 ();

    // Gate block model: 0 good, 1 nAornB stuck 0, 2 nAornB=~A&~B, 3 xor per-vector mask
    function automatic logic [2:0] gate_resp(input int md, input logic [2:0] m,
                                             input logic a, input logic b);
        logic [2:0] r;
        r = {~a, ~b, ~a | ~b};
        case (md)
            1: r[0] = 1'b0;
            2: r[0] = ~a & ~b;
            3: r = r ^ m;
            default: ;
        endcase
        return r;
    endfunction

    always_comb {g0.na_in, g0.nb_in, g0.naornb_in} = gate_resp(mode, mask[{g0.a_out, g0.b_out}], g0.a_out, g0.b_out);
    always_comb {g1.na_in, g1.nb_in, g1.naornb_in} = gate_resp(mode, mask[{g1.a_out, g1.b_out}], g1.a_out, g1.b_out);
    always_comb {g2.na_in, g2.nb_in, g2.naornb_in} = gate_resp(mode, mask[{g2.a_out, g2.b_out}], g2.a_out, g2.b_out);

    logic       busy0, done0, pass0, ffv0;
    logic       busy1, done1, pass1, ffv1;
    logic       busy2, done2, pass2, ffv2;
    logic [7:0] err0, err2;
    logic [1:0] err1;
    logic [1:0] ff0, ff1, ff2;

    demorgan_sweep_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .gate(g0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ff0), .first_fail_valid(ffv0));

    demorgan_sweep_checker #(.NUM_PASSES(2), .SETTLE_CYCLES(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .gate(g1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ff1), .first_fail_valid(ffv1));

    demorgan_sweep_checker #(.NUM_PASSES(1), .SETTLE_CYCLES(3), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .gate(g2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ff2), .first_fail_valid(ffv2));

    int npass [3] = '{1, 2, 1};
    int nsett [3] = '{1, 1, 3};
    int cntw  [3] = '{8, 2, 8};

    int         sel;
    logic       m_busy, m_done, m_pass, m_ffv, m_a, m_b;
    logic [1:0] m_ff;
    int         m_err;

    always_comb begin
        m_busy = busy0; m_done = done0; m_pass = pass0; m_ffv = ffv0;
        m_ff = ff0; m_err = int'(err0); m_a = g0.a_out; m_b = g0.b_out;
        if (sel == 1) begin
            m_busy = busy1; m_done = done1; m_pass = pass1; m_ffv = ffv1;
            m_ff = ff1; m_err = int'(err1); m_a = g1.a_out; m_b = g1.b_out;
        end else if (sel == 2) begin
            m_busy = busy2; m_done = done2; m_pass = pass2; m_ffv = ffv2;
            m_ff = ff2; m_err = int'(err2); m_a = g2.a_out; m_b = g2.b_out;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One full run on instance s; cycle 1 is the cycle after the edge that samples start.
    task automatic run_and_check(input int s, input bit pulses, input int e_err,
                                 input int e_ffv, input int e_ff, input int e_pass,
                                 input int e_cyc, input string tag);
        int cyc, dcyc, seq_bad, busy_bad, post_bad, vexp;
        sel = s;
        @(negedge clk);
        start_v[s] = 1'b1;
        @(posedge clk);
        #1 start_v[s] = 1'b0;
        cyc = 1; dcyc = 0; seq_bad = 0; busy_bad = 0; post_bad = 0;
        while (cyc <= 300) begin
            if (m_done) begin
                dcyc = cyc;
                if (pulses) start_v[s] = 1'b1;
                break;
            end
            vexp = ((cyc - 1) / (nsett[s] + 1)) % 4;
            if (int'({m_a, m_b}) != vexp) seq_bad++;
            if (!m_busy) busy_bad++;
            start_v[s] = (pulses && (cyc == 3 || cyc == 4)) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, " done_cycle"}, dcyc, e_cyc);
        check({tag, " vector_seq"}, seq_bad, 0);
        check({tag, " busy_during_run"}, busy_bad, 0);
        check({tag, " busy_in_done"}, int'(m_busy), 0);
        check({tag, " err_count"}, m_err, e_err);
        check({tag, " first_fail_valid"}, int'(m_ffv), e_ffv);
        if (e_ffv != 0) check({tag, " first_fail_vec"}, int'(m_ff), e_ff);
        check({tag, " pass"}, int'(m_pass), e_pass);
        @(posedge clk);
        #1 start_v[s] = 1'b0;
        check({tag, " ab_idle"}, int'({m_a, m_b}), 0);
        repeat (3) begin
            @(posedge clk);
            #1 if (m_busy || m_done) post_bad++;
        end
        check({tag, " idle_after_done"}, post_bad, 0);
        check({tag, " pass_held"}, int'(m_pass), e_pass);
    endtask

    typedef struct {
        int    inst;
        int    md;
        int    e_err;
        int    e_ffv;
        int    e_ff;
        int    e_pass;
        int    e_cyc;
        string tag;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int cnt, first, seen, na, nb, no, sat, rr;
        logic [2:0] r;
        logic [1:0] v2;

        tbl[0] = '{0, 0, 0, 0, 0, 1, 9,  "good"};
        tbl[1] = '{0, 1, 3, 1, 0, 0, 9,  "nor_stuck0"};
        tbl[2] = '{0, 2, 2, 1, 1, 0, 9,  "nor_is_and"};
        tbl[3] = '{1, 1, 3, 1, 0, 0, 17, "sat_2pass"};
        tbl[4] = '{2, 0, 0, 0, 0, 1, 17, "settle3"};

        rst_n = 1'b0; start_v = '0; mode = 0; sel = 0;
        for (int i = 0; i < 4; i++) mask[i] = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst ab", int'({g0.a_out, g0.b_out}), 0);
        check("rst busy_done_pass", int'({busy0, done0, pass0}), 0);
        check("rst err", int'(err0), 0);
        check("rst first_fail", int'({ffv0, ff0}), 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].md;
            run_and_check(tbl[i].inst, 1'b0, tbl[i].e_err, tbl[i].e_ffv, tbl[i].e_ff,
                          tbl[i].e_pass, tbl[i].e_cyc, tbl[i].tag);
        end

        // Random fault masks against a vector-level model of the sweep.
        mode = 3;
        for (int it = 0; it < 8; it++) begin
            rr = $urandom_range(0, 2);
            for (int v = 0; v < 4; v++)
                mask[v] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
            cnt = 0; first = -1;
            for (int p = 0; p < npass[rr]; p++) begin
                for (int v = 0; v < 4; v++) begin
                    v2 = 2'(v);
                    r  = gate_resp(3, mask[v], v2[1], v2[0]);
                    na = 1 - (v / 2);
                    nb = 1 - (v % 2);
                    no = (v == 3) ? 0 : 1;
                    if (int'(r[2]) != na || int'(r[1]) != nb || int'(r[0]) != no) begin
                        cnt++;
                        if (first < 0) first = v;
                    end
                end
            end
            sat = (cnt > (1 << cntw[rr]) - 1) ? (1 << cntw[rr]) - 1 : cnt;
            run_and_check(rr, 1'b0, sat, (first >= 0) ? 1 : 0, (first >= 0) ? first : 0,
                          (cnt == 0) ? 1 : 0, 1 + 4 * npass[rr] * (nsett[rr] + 1), "random");
        end

        // Reset during the CHECK of vector 10 abandons the run.
        mode = 1; sel = 0;
        @(negedge clk) start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset ab", int'({g0.a_out, g0.b_out}), 2);
        check("pre_reset err", int'(err0), 2);
        rst_n = 1'b0;
        #1;
        check("mid_reset outputs", int'({g0.a_out, g0.b_out, busy0, done0, pass0, ffv0, ff0}), 0);
        check("mid_reset err", int'(err0), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done0 || busy0) seen++;
        end
        check("no_done_after_reset", seen, 0);

        mode = 0;
        run_and_check(0, 1'b1, 0, 0, 0, 1, 9, "start_while_busy");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demorgan_sweep_checker.md
Name: demorgan_sweep_checker

Overview:
Self-sequencing stimulus driver and response checker for the demorgan gate block, wired around it. It sweeps A/B through all four combinations in truth-table order (00, 01, 10, 11). For each combination it samples the block's nA, nB and nAornB outputs after a settle delay and compares them against the De Morgan expectation. It reports an error count, the first failing vector, and pass/done status.

Parameters:
NUM_PASSES  1  number of full 4-vector sweeps per run (>=1)
SETTLE_CYCLES  1  cycles each vector is held before sampling (>=1)
CNT_W  8  width of error counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; ignored while busy
a_out  out  1  A stimulus to the gate block (registered)
b_out  out  1  B stimulus to the gate block (registered)
na_in  in  1  nA response
nb_in  in  1  nB response
naornb_in  in  1  nA+nB response
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse at end of run
pass  out  1  1 when err_count==0 at end of run; held until next accepted start
err_count  out  CNT_W  mismatched vectors this run, saturating at 2^CNT_W-1
first_fail_vec  out  2  {A,B} of first mismatching vector this run
first_fail_valid  out  1  first_fail_vec holds a captured value

Behaviour:
- Reset (asynchronous, any state): state=IDLE and all outputs 0. This includes a_out, b_out, err_count and first_fail_*. A reset mid-run abandons the run; no done pulse is generated.
- Expected responses: nA=~A, nB=~B, nAornB=~A|~B.
- A vector mismatches if any of the three inputs differs from its expected value. Unknown (X/Z) input values count as a mismatch.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 is accepted.
  - On acceptance: load vector 00 onto a_out/b_out; clear err_count, first_fail_*, pass and the pass counter; settle counter=0; go to SETTLE.
- SETTLE:
  - busy=1.
  - Settle counter increments each cycle.
  - When the count reaches SETTLE_CYCLES-1, go to CHECK.
- CHECK (one cycle):
  - Inputs are compared against the expectation for the current a_out/b_out.
  - On mismatch: err_count increments, holding at its maximum once saturated. If first_fail_valid=0, capture {a_out,b_out} and set first_fail_valid=1.
  - If current vector is 11 and this is pass NUM_PASSES: go to DONE.
  - Otherwise advance to the next vector (11 wraps to 00 and increments the pass counter), clear the settle counter, and go to SETTLE.
- DONE (one cycle):
  - done=1, busy=0.
  - pass is set to (err_count==0), including any error from the final CHECK.
  - a_out/b_out return to 0; go to IDLE.
- err_count and first_fail_* hold their values in IDLE until the next accepted start.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. done is high in cycle 1+4*NUM_PASSES*(SETTLE_CYCLES+1) after the edge that samples start (cycle 9 with defaults).
- start is ignored while busy or in DONE. It is level-sampled in IDLE only.
- a_out/b_out change only on entry to SETTLE, so they are stable for the whole settle+check window.

Decomposition:
- Package demorgan_chk_pkg:
  - state enum (IDLE, SETTLE, CHECK, DONE);
  - constant NUM_VECTORS=4;
  - constant LAST_VEC=2'b11;
  - function returning the expected {nA,nB,nAornB} for a 2-bit vector.
- One sub-module, demorgan_expect: combinational expected-response model plus 3-bit compare, outputting a mismatch flag. Instantiated once.
- FSM, counters and capture registers live in the top module.

Test Plan:
- Correct gate block, defaults, start at edge 0 -> a_out/b_out sequence 00,01,10,11; done in cycle 9; pass=1; err_count=0; first_fail_valid=0.
- naornb_in stuck at 0 -> err_count=3; first_fail_vec=00; pass=0.
- Faulty block with nAornB=~A&~B -> mismatches at 01 and 10; err_count=2; first_fail_vec=01; pass=0.
- NUM_PASSES=2, CNT_W=2, naornb_in stuck 0 -> 6 raw mismatches saturate to err_count=3; done in cycle 17.
- SETTLE_CYCLES=3, correct block -> each vector held 4 cycles; done in cycle 17; pass=1.
- rst_n low during the vector-10 CHECK -> all outputs 0 immediately, no done. start pulses while busy on a fresh run are ignored; that run completes normally with done in cycle 9 and pass=1.
